// File: rtl/wshb_arbiter_if.sv
`default_nettype none
// ============================================================================
// wshb_arbiter_if : one Wishbone link, seen from the master or the slave side
// Rev 1.0
// ============================================================================
interface wshb_arbiter_if #(
    parameter int AW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat_ms;
    logic [3:0]    sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [31:0]   dat_sm;
    logic          ack;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack
    );
endinterface
`default_nettype wire

// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
// wshb_arbiter : two-master / one-slave Wishbone arbiter, round-robin grant
//                with optional transfer quota (macro WSHB_ARB_QUOTA_EN)
// Rev 1.0
// ============================================================================
module wshb_arbiter #(
    parameter int MAX_XFER = 16,
    parameter int AW       = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    wshb_arbiter_if.slave  m0,
    wshb_arbiter_if.slave  m1,
    wshb_arbiter_if.master s,
    output logic [1:0]     gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last;
    logic [1:0] r_gnt;
    logic       w_quota;
    logic       w_leave;

    if (MAX_XFER < 1) begin : g_bad_max_xfer
        $error("wshb_arbiter: MAX_XFER must be >= 1");
    end

    if (AW < 1) begin : g_bad_aw
        $error("wshb_arbiter: AW must be >= 1");
    end

    // Owner gives up the bus when it drops cyc, or when its quota expires
    // while the other master is waiting.
    assign w_leave = ((r_state == OWN0) && (!m0.cyc || (w_quota && m1.cyc))) ||
                     ((r_state == OWN1) && (!m1.cyc || (w_quota && m0.cyc)));

`ifdef WSHB_ARB_QUOTA_EN
    localparam int            CW         = $clog2(MAX_XFER + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(MAX_XFER - 1);
    localparam logic [CW-1:0] C_CNT_MAX  = CW'(MAX_XFER);

    logic [CW-1:0] r_xfer_cnt;

    // A saturated counter keeps the quota expired, so a master that starts
    // waiting late is still let in on the owner's next ack.
    assign w_quota = s.ack && (r_xfer_cnt >= C_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if ((r_state == IDLE) || w_leave) begin
            r_xfer_cnt <= '0;
        end else if (s.ack && (r_xfer_cnt != C_CNT_MAX)) begin
            r_xfer_cnt <= r_xfer_cnt + CW'(1);
        end
    end
`else
    assign w_quota = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0.cyc && (!m1.cyc || r_last)) begin
                        r_state <= OWN0;
                        r_gnt   <= 2'b01;
                    end else if (m1.cyc) begin
                        r_state <= OWN1;
                        r_gnt   <= 2'b10;
                    end
                end
                OWN0: begin
                    if (w_leave) begin
                        r_last <= 1'b0;
                        if (m1.cyc) begin
                            r_state <= OWN1;
                            r_gnt   <= 2'b10;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 2'b00;
                        end
                    end
                end
                OWN1: begin
                    if (w_leave) begin
                        r_last <= 1'b1;
                        if (m0.cyc) begin
                            r_state <= OWN0;
                            r_gnt   <= 2'b01;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 2'b00;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = {AW{1'b0}};
        s.dat_ms = 32'd0;
        s.sel    = 4'd0;
        s.cti    = 3'd0;
        s.bte    = 2'd0;
        case (r_state)
            OWN0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.dat_ms = m0.dat_ms;
                s.sel    = m0.sel;
                s.cti    = m0.cti;
                s.bte    = m0.bte;
            end
            OWN1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.dat_ms = m1.dat_ms;
                s.sel    = m1.sel;
                s.cti    = m1.cti;
                s.bte    = m1.bte;
            end
            default: ;
        endcase
    end

    // Read data fans out to both masters; only the ack qualifies it.
    assign m0.dat_sm = s.dat_sm;
    assign m1.dat_sm = s.dat_sm;
    assign m0.ack    = s.ack & r_gnt[0];
    assign m1.ack    = s.ack & r_gnt[1];
    assign gnt       = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wshb_arbiter : directed self-checking bench for wshb_arbiter
// Rev 1.0
// ============================================================================
module tb_wshb_arbiter;

    localparam int AW       = 32;
    localparam int MAX_XFER = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    int         n_checks = 0;
    int         n_errors = 0;

    wshb_arbiter_if #(.AW(AW)) m0_bus ();
    wshb_arbiter_if #(.AW(AW)) m1_bus ();
    wshb_arbiter_if #(.AW(AW)) s_bus ();

    wshb_arbiter #(
        .MAX_XFER (MAX_XFER),
        .AW       (AW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus),
        .gnt (gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic on);
        m0_bus.cyc = on;
        m0_bus.stb = on;
    endtask

    task automatic set_m1(input logic on);
        m1_bus.cyc = on;
        m1_bus.stb = on;
    endtask

    int   cnt;
    int   bad;
    int   n0;
    int   n1;
    int   idx;
    int   both;
    logic phase;
    logic a0;
    logic a1;

    initial begin
        rst            = 1'b1;
        set_m0(1'b1);
        set_m1(1'b1);
        m0_bus.we      = 1'b1;
        m0_bus.adr     = 32'h100;
        m0_bus.dat_ms  = 32'hA5A5_0001;
        m0_bus.sel     = 4'hF;
        m0_bus.cti     = 3'b010;
        m0_bus.bte     = 2'b00;
        m1_bus.we      = 1'b0;
        m1_bus.adr     = 32'h200;
        m1_bus.dat_ms  = 32'h5A5A_0002;
        m1_bus.sel     = 4'h3;
        m1_bus.cti     = 3'b111;
        m1_bus.bte     = 2'b01;
        s_bus.ack      = 1'b0;
        s_bus.dat_sm   = 32'hDEAD_BEEF;

        // Reset held with both masters requesting
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("rst_s_stb", 32'(s_bus.stb), 32'd0);
        check("rst_s_adr", s_bus.adr, 32'd0);
        check("rst_s_dat", s_bus.dat_ms, 32'd0);
        s_bus.ack = 1'b1;
        #1;
        check("rst_m0_ack", 32'(m0_bus.ack), 32'd0);
        check("rst_m1_ack", 32'(m1_bus.ack), 32'd0);
        s_bus.ack = 1'b0;
        rst       = 1'b0;
        tick();
        check("first_tie_gnt", 32'(gnt), 32'h1);
        check("m0_mux_adr", s_bus.adr, 32'h100);
        check("m0_mux_dat", s_bus.dat_ms, 32'hA5A5_0001);
        check("m0_mux_ctl", {22'd0, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel, s_bus.cti, s_bus.bte},
              {22'd0, 1'b1, 1'b1, 1'b1, 4'hF, 3'b010, 2'b00});

        // Both release: back to idle
        set_m0(1'b0);
        set_m1(1'b0);
        tick();
        check("release_gnt", 32'(gnt), 32'd0);
        check("release_s_cyc", 32'(s_bus.cyc), 32'd0);

        // Single requester m1
        set_m1(1'b1);
        m1_bus.adr = 32'h40;
        #1;
        check("single_latency_adr", s_bus.adr, 32'd0);
        tick();
        check("single_gnt", 32'(gnt), 32'h2);
        check("single_adr", s_bus.adr, 32'h40);
        check("m1_mux_ctl", {22'd0, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel, s_bus.cti, s_bus.bte},
              {22'd0, 1'b1, 1'b1, 1'b0, 4'h3, 3'b111, 2'b01});
        s_bus.ack = 1'b1;
        #1;
        check("single_m1_ack", 32'(m1_bus.ack), 32'd1);
        check("single_m0_ack", 32'(m0_bus.ack), 32'd0);
        check("single_m1_dat", m1_bus.dat_sm, 32'hDEAD_BEEF);
        check("single_m0_dat", m0_bus.dat_sm, 32'hDEAD_BEEF);
        tick();
        s_bus.ack = 1'b0;

        // Tie after m1 ownership goes to m0
        set_m1(1'b0);
        tick();
        check("idle_after_m1", 32'(gnt), 32'd0);
        set_m0(1'b1);
        set_m1(1'b1);
        tick();
        check("tie_last1_gnt", 32'(gnt), 32'h1);

        // Voluntary release after two acks, m1 waiting
        for (int i = 0; i < 2; i++) begin
            s_bus.ack = 1'b1;
            #1;
            check("vol_m0_ack", 32'({m1_bus.ack, m0_bus.ack}), 32'h1);
            tick();
            s_bus.ack = 1'b0;
            tick();
        end
        set_m0(1'b0);
        tick();
        check("vol_handover_gnt", 32'(gnt), 32'h2);
        set_m0(1'b1);
        phase = 1'b0;

`ifdef WSHB_ARB_QUOTA_EN
        // Fresh quota for m1 after the voluntary handover
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (gnt != 2'b10) begin
                s_bus.ack = 1'b0;
                break;
            end
            phase     = ~phase;
            s_bus.ack = phase & s_bus.cyc & s_bus.stb;
            #1;
            if (m1_bus.ack) cnt++;
        end
        s_bus.ack = 1'b0;
        check("vol_m1_quota", 32'(cnt), 32'd4);
        check("vol_back_to_m0", 32'(gnt), 32'h1);

        // Quota round-robin with both masters always requesting
        m0_bus.adr = 32'h1000;
        m1_bus.adr = 32'h2000;
        a0 = 1'b0; a1 = 1'b0; idx = 0; n0 = 0; n1 = 0; both = 0; phase = 1'b0;
        for (int c = 0; c < 200 && idx < 16; c++) begin
            tick();
            if (a0) m0_bus.adr = m0_bus.adr + 32'd4;
            if (a1) m1_bus.adr = m1_bus.adr + 32'd4;
            phase     = ~phase;
            s_bus.ack = phase & s_bus.cyc & s_bus.stb;
            #1;
            a0 = m0_bus.ack;
            a1 = m1_bus.ack;
            if (a0 && a1) both++;
            if (a0 || a1) begin
                check("q_owner", 32'(a1), 32'((idx / 4) % 2));
                check("q_adr", s_bus.adr, a1 ? 32'h2000 + 32'(4 * n1) : 32'h1000 + 32'(4 * n0));
                if (a1) n1++; else n0++;
                idx++;
            end
        end
        tick();
        s_bus.ack = 1'b0;
        if (a0) m0_bus.adr = m0_bus.adr + 32'd4;
        if (a1) m1_bus.adr = m1_bus.adr + 32'd4;
        check("q_total", 32'(idx), 32'd16);
        check("q_both_ack", 32'(both), 32'd0);
        check("q_m0_adr", m0_bus.adr, 32'h1020);
        check("q_m1_adr", m1_bus.adr, 32'h2020);
`else
        // Without quota m1 keeps the bus as long as it holds cyc
        bad = 0; cnt = 0; n0 = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            phase     = ~phase;
            s_bus.ack = phase & s_bus.cyc & s_bus.stb;
            #1;
            if (gnt != 2'b10) bad++;
            if (m0_bus.ack) n0++;
            if (m1_bus.ack) cnt++;
        end
        s_bus.ack = 1'b0;
        check("starve_gnt_bad_cycles", 32'(bad), 32'd0);
        check("starve_m0_acks", 32'(n0), 32'd0);
        check("starve_m1_acks", 32'(cnt), 32'd500);
`endif

        // Tie after m0 ownership goes to m1
        set_m0(1'b0);
        set_m1(1'b0);
        tick();
        check("idle_again", 32'(gnt), 32'd0);
        set_m0(1'b1);
        tick();
        check("m0_alone_gnt", 32'(gnt), 32'h1);
        set_m0(1'b0);
        tick();
        check("m0_drop_idle_cyc", 32'(s_bus.cyc), 32'd0);
        set_m0(1'b1);
        set_m1(1'b1);
        tick();
        check("tie_last0_gnt", 32'(gnt), 32'h2);

        // Reset in the middle of an m0 transfer
        set_m0(1'b0);
        set_m1(1'b0);
        tick();
        set_m0(1'b1);
        tick();
        s_bus.ack = 1'b1;
        #1;
        check("pre_rst_m0_ack", 32'(m0_bus.ack), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_s_cyc", 32'(s_bus.cyc), 32'd0);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_m0_ack", 32'(m0_bus.ack), 32'd0);
        set_m1(1'b1);
        tick();
        rst       = 1'b0;
        s_bus.ack = 1'b0;
        tick();
        check("post_rst_tie_gnt", 32'(gnt), 32'h1);
        check("post_rst_s_cyc", 32'(s_bus.cyc), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
